// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul accelerator APB requester: FSM encoding,
// default geometry and the accelerator register map used by bench and firmware.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUS_WIDTH  = 16;
    localparam int MAX_DIM        = DEF_BUS_WIDTH / DEF_DATA_WIDTH;

    // Accelerator register offsets
    localparam logic [31:0] REG_CTRL         = 32'h0000_0000;
    localparam logic [31:0] REG_OPERAND_A    = 32'h0000_0004;
    localparam logic [31:0] REG_OPERAND_B    = 32'h0000_0008;
    localparam logic [31:0] REG_FLAGS        = 32'h0000_000C;
    localparam logic [31:0] REG_SCRATCH_BASE = 32'h0000_0020;

endpackage

// File: rtl/matmul_apb_master.sv
// APB requester feeding the matmul accelerator: turns one host command into
// exactly one APB transfer and returns data/status on a response handshake.
module matmul_apb_master
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]            cmd_data_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [BUS_WIDTH-1:0]            rsp_data_o,
    output logic                            rsp_err_o,
    output logic                            rsp_timeout_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    input  logic                            pready_i,
    input  logic                            pslverr_i,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    input  logic                            busy_i
);

    localparam int STRB_W = BUS_WIDTH / DATA_WIDTH;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_t             state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   psel_r, psel_s;
    logic                   penable_r, penable_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic                   pwrite_r, pwrite_s;
    logic [STRB_W-1:0]      pstrb_r, pstrb_s;
    logic [BUS_WIDTH-1:0]   pwdata_r, pwdata_s;
    logic [ADDR_WIDTH-1:0]  paddr_r, paddr_s;
    logic [BUS_WIDTH-1:0]   rsp_data_r, rsp_data_s;
    logic                   rsp_err_r, rsp_err_s;
    logic                   rsp_timeout_r, rsp_timeout_s;

    // State and all output registers; reset clears them asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b0;
            pwrite_r      <= 1'b0;
            pstrb_r       <= {STRB_W{1'b0}};
            pwdata_r      <= {BUS_WIDTH{1'b0}};
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            rsp_data_r    <= {BUS_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            rsp_valid_r   <= rsp_valid_s;
            pwrite_r      <= pwrite_s;
            pstrb_r       <= pstrb_s;
            pwdata_r      <= pwdata_s;
            paddr_r       <= paddr_s;
            rsp_data_r    <= rsp_data_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        psel_s        = 1'b0;
        penable_s     = 1'b0;
        rsp_valid_s   = 1'b0;
        pwrite_s      = pwrite_r;
        pstrb_s       = pstrb_r;
        pwdata_s      = pwdata_r;
        paddr_s       = paddr_r;
        rsp_data_s    = rsp_data_r;
        rsp_err_s     = rsp_err_r;
        rsp_timeout_s = rsp_timeout_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i && !busy_i) begin
                    state_s  = ST_SETUP;
                    cnt_s    = {CNT_W{1'b0}};
                    psel_s   = 1'b1;
                    pwrite_s = cmd_write_i;
                    paddr_s  = cmd_addr_i;
                    // Reads never present stale write data or strobes on the bus
                    if (cmd_write_i) begin
                        pwdata_s = cmd_data_i;
                        pstrb_s  = cmd_strb_i;
                    end else begin
                        pwdata_s = {BUS_WIDTH{1'b0}};
                        pstrb_s  = {STRB_W{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                // pready in the last allowed cycle still completes normally
                if (pready_i) begin
                    state_s       = ST_RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_data_s    = pwrite_r ? {BUS_WIDTH{1'b0}} : prdata_i;
                    rsp_err_s     = pslverr_i;
                    rsp_timeout_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s       = ST_RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_data_s    = {BUS_WIDTH{1'b0}};
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                end else begin
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Ready is combinational so a falling busy is honoured in the same cycle
    assign cmd_ready_o   = (state_r == ST_IDLE) && !busy_i && !rst_i;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign pwrite_o      = pwrite_r;
    assign pstrb_o       = pstrb_r;
    assign pwdata_o      = pwdata_r;
    assign paddr_o       = paddr_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;

endmodule
